// File: rtl/xy_flit_injector_if.sv
// Request, payload, flit and credit signals shared by a packet source,
// the flit injector and the router's local input port.
interface xy_flit_injector_if #(
    parameter int COORD_W = 3,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [LEN_W-1:0]   req_len;
    logic               pay_valid;
    logic               pay_ready;
    logic [DATA_W-1:0]  pay_data;
    logic               flit_valid;
    logic [DATA_W+1:0]  flit_data;
    logic               credit_ret;

    modport master (
        output req_valid, req_x, req_y, req_len, pay_valid, pay_data, credit_ret,
        input  req_ready, pay_ready, flit_valid, flit_data
    );

    modport slave (
        input  req_valid, req_x, req_y, req_len, pay_valid, pay_data, credit_ret,
        output req_ready, pay_ready, flit_valid, flit_data
    );
endinterface

// File: rtl/xy_flit_injector.sv
// Credit-flow-controlled packet injector for an XY mesh router: emits a head flit
// carrying the lookahead output port, then the body flits with the last one typed tail.
module xy_flit_injector #(
    parameter int COORD_W = 3,
    parameter int DATA_W  = 16,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CREDITS = 4,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic              clk,
    input  logic              rst,
    xy_flit_injector_if.slave bus,
    output logic              err_req,
    output logic              err_credit,
    output logic              busy
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    localparam logic [1:0]         TYPE_BODY   = 2'b00;
    localparam logic [1:0]         TYPE_HEAD   = 2'b01;
    localparam logic [1:0]         TYPE_TAIL   = 2'b10;
    localparam logic [1:0]         TYPE_SINGLE = 2'b11;
    localparam logic [CNT_W-1:0]   CREDIT_MAX  = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_ZERO    = LEN_W'(0);
    localparam logic [LEN_W-1:0]   LEN_ONE     = LEN_W'(1);
    localparam logic [COORD_W-1:0] LX          = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY          = COORD_W'(LOCAL_Y);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [LEN_W-1:0]   cnt_next_s;
    logic [2:0]         port_r;
    logic [CNT_W-1:0]   credit_r;
    logic               flit_valid_r;
    logic [DATA_W+1:0]  flit_data_r;
    logic [DATA_W+1:0]  flit_next_s;
    logic               err_req_r;
    logic               err_req_next_s;
    logic               err_credit_r;

    logic               credit_avail_s;
    logic               req_ready_s;
    logic               pay_ready_s;
    logic               req_fire_s;
    logic               req_bad_s;
    logic               pay_fire_s;
    logic               latch_req_s;
    logic               send_s;

    // X-first routing: resolve the X offset before looking at Y.
    function automatic logic [2:0] xy_port(input logic [COORD_W-1:0] dx,
                                           input logic [COORD_W-1:0] dy);
        logic [2:0] p;
        if (dx > LX) begin
            p = 3'd1;
        end else if (dx < LX) begin
            p = 3'd2;
        end else if (dy > LY) begin
            p = 3'd3;
        end else begin
            p = 3'd4;
        end
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] head_payload(input logic [2:0]         p,
                                                       input logic [COORD_W-1:0] hx,
                                                       input logic [COORD_W-1:0] hy,
                                                       input logic [LEN_W-1:0]   hl);
        return DATA_W'({p, hx, hy, hl});
    endfunction

    // Handshake qualifiers; ready signals depend only on registered state and rst.
    always_comb begin
        credit_avail_s = (credit_r != CNT_ZERO);
        req_ready_s    = !rst && (state_r == ST_IDLE);
        pay_ready_s    = !rst && (state_r == ST_BODY) && credit_avail_s;
        req_fire_s     = bus.req_valid && req_ready_s;
        pay_fire_s     = bus.pay_valid && pay_ready_s;
        req_bad_s      = ((bus.req_x == LX) && (bus.req_y == LY)) || (bus.req_len > LEN_MAX);
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.pay_ready  = pay_ready_s;
    assign bus.flit_valid = flit_valid_r;
    assign bus.flit_data  = flit_data_r;
    assign err_req        = err_req_r;
    assign err_credit     = err_credit_r;
    assign busy           = (state_r != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, flit construction and request checking.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        flit_next_s    = flit_data_r;
        latch_req_s    = 1'b0;
        send_s         = 1'b0;
        err_req_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    if (req_bad_s) begin
                        err_req_next_s = 1'b1;
                    end else begin
                        latch_req_s  = 1'b1;
                        state_next_s = ST_HEAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (credit_avail_s) begin
                    send_s     = 1'b1;
                    cnt_next_s = LEN_ZERO;
                    if (len_r == LEN_ZERO) begin
                        flit_next_s  = {TYPE_SINGLE, head_payload(port_r, x_r, y_r, len_r)};
                        state_next_s = ST_IDLE;
                    end else begin
                        flit_next_s  = {TYPE_HEAD, head_payload(port_r, x_r, y_r, len_r)};
                        state_next_s = ST_BODY;
                    end
                end else begin
                    state_next_s = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (pay_fire_s) begin
                    send_s     = 1'b1;
                    cnt_next_s = cnt_r + LEN_ONE;
                    if ((cnt_r + LEN_ONE) == len_r) begin
                        flit_next_s  = {TYPE_TAIL, bus.pay_data};
                        state_next_s = ST_IDLE;
                    end else begin
                        flit_next_s  = {TYPE_BODY, bus.pay_data};
                        state_next_s = ST_BODY;
                    end
                end else begin
                    state_next_s = ST_BODY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Packet descriptor captured at request acceptance, plus the body counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= {COORD_W{1'b0}};
            y_r    <= {COORD_W{1'b0}};
            len_r  <= LEN_ZERO;
            port_r <= 3'd0;
            cnt_r  <= LEN_ZERO;
        end else begin
            if (latch_req_s) begin
                x_r    <= bus.req_x;
                y_r    <= bus.req_y;
                len_r  <= bus.req_len;
                port_r <= xy_port(bus.req_x, bus.req_y);
            end
            cnt_r <= cnt_next_s;
        end
    end

    // Output registers: flit strobe pulses once per send, data holds between flits.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_valid_r <= 1'b0;
            flit_data_r  <= {(DATA_W + 2){1'b0}};
            err_req_r    <= 1'b0;
        end else begin
            flit_valid_r <= send_s;
            flit_data_r  <= flit_next_s;
            err_req_r    <= err_req_next_s;
        end
    end

    // Credit counter; a return with no room left saturates and raises the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r     <= CREDIT_MAX;
            err_credit_r <= 1'b0;
        end else begin
            case ({bus.credit_ret, send_s})
                2'b10: begin
                    if (credit_r == CREDIT_MAX) begin
                        err_credit_r <= 1'b1;
                    end else begin
                        credit_r <= credit_r + CNT_ONE;
                    end
                end
                2'b01:   credit_r <= credit_r - CNT_ONE;
                default: credit_r <= credit_r;
            endcase
        end
    end
endmodule

// File: tb/tb_xy_flit_injector.sv
// Scoreboard bench for xy_flit_injector: directed scenarios plus randomized packets
// with a credit-returning router model.
module tb_xy_flit_injector;
    localparam int COORD_W = 3;
    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CREDITS = 4;
    localparam int LOCAL_X = 0;
    localparam int LOCAL_Y = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_req;
    logic err_credit;
    logic busy;
    logic router_ret = 1'b0;
    logic dir_ret = 1'b0;
    bit   router_en = 1'b0;
    bit   abort = 1'b0;

    xy_flit_injector_if #(.COORD_W(COORD_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

    xy_flit_injector #(
        .COORD_W(COORD_W), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .CREDITS(CREDITS), .LOCAL_X(LOCAL_X), .LOCAL_Y(LOCAL_Y)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .err_req(err_req), .err_credit(err_credit), .busy(busy)
    );

    always #5 clk = ~clk;

    assign bus.credit_ret = router_en ? router_ret : dir_ret;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int flit_cnt = 0;
    int err_seen = 0;
    int exp_err = 0;
    int occ = 0;
    int flit_cyc[$];
    logic [DATA_W+1:0] exp_q[$];
    logic [DATA_W+1:0] mon_exp;
    logic [DATA_W+1:0] last_flit = '0;
    logic [DATA_W-1:0] pay_tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference head flit: type, then {port, x, y, len} packed with plain arithmetic.
    function automatic logic [DATA_W+1:0] model_head(input int x, input int y, input int len);
        int port;
        if (x > LOCAL_X)      port = 1;
        else if (x < LOCAL_X) port = 2;
        else if (y > LOCAL_Y) port = 3;
        else                  port = 4;
        return {(len == 0) ? 2'b11 : 2'b01, 16'(port * 1024 + x * 128 + y * 16 + len)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each flit and checks data holds between flits.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            last_flit = '0;
        end else begin
            if (err_req) err_seen++;
            if (bus.flit_valid) begin
                flit_cnt++;
                flit_cyc.push_back(cyc);
                last_flit = bus.flit_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("flit_data", bus.flit_data, mon_exp);
                end
            end else begin
                check("flit_hold", bus.flit_data, last_flit);
            end
        end
    end

    // Router model: buffers each flit and frees slots at random.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            occ = 0;
            router_ret = 1'b0;
        end else if (router_en) begin
            if (bus.flit_valid) occ++;
            if (occ > 0 && $urandom_range(0, 2) != 0) begin
                router_ret = 1'b1;
                occ--;
            end else begin
                router_ret = 1'b0;
            end
        end else begin
            router_ret = 1'b0;
        end
    end

    task automatic do_reset();
        tick();
        rst = 1'b1;
        abort = 1'b1;
        dir_ret = 1'b0;
        bus.req_valid = 1'b0;
        bus.pay_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_req_ready", bus.req_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("rst_req_ready_idle", bus.req_ready, 1'b1);
        check("rst_pay_ready", bus.pay_ready, 1'b0);
        check("rst_flit_valid", bus.flit_valid, 1'b0);
        check("rst_flit_data", bus.flit_data, 18'd0);
        check("rst_err_req", err_req, 1'b0);
        check("rst_err_credit", err_credit, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick();
    endtask

    task automatic send_packet(input int x, input int y, input int len, input bit gaps);
        int n;
        bit bad;
        bus.req_valid = 1'b1;
        bus.req_x = COORD_W'(x);
        bus.req_y = COORD_W'(y);
        bus.req_len = LEN_W'(len);
        n = 0;
        while (!bus.req_ready && n < 200 && !abort) begin
            tick();
            n++;
        end
        if (n >= 200) check("req_timeout", bus.req_ready, 1'b1);
        if (abort || n >= 200) begin
            bus.req_valid = 1'b0;
            return;
        end
        tick();
        bus.req_valid = 1'b0;
        bad = (x == LOCAL_X && y == LOCAL_Y) || len > MAX_LEN;
        if (bad) begin
            exp_err++;
            return;
        end
        exp_q.push_back(model_head(x, y, len));
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1) ? 2'b10 : 2'b00, pay_tbl[i]});
        for (int i = 0; i < len && !abort; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0 && !abort) tick();
            end
            bus.pay_valid = 1'b1;
            bus.pay_data = pay_tbl[i];
            n = 0;
            while (!bus.pay_ready && n < 200 && !abort) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                check("pay_timeout", bus.pay_ready, 1'b1);
                break;
            end
            if (!abort) tick();
            bus.pay_valid = 1'b0;
        end
        bus.pay_valid = 1'b0;
    endtask

    task automatic wait_flits(input string name, input int target, input int bound);
        int n = 0;
        while (flit_cnt < target && n < bound) begin
            tick();
            n++;
        end
        check(name, flit_cnt, target);
    endtask

    initial begin
        int base;
        int n;
        bus.req_valid = 1'b0;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_len = '0;
        bus.pay_valid = 1'b0;
        bus.pay_data = '0;
        do_reset();

        // Two-body packet to (3,2): three back-to-back flits, one credit left.
        pay_tbl[0] = 16'hAAAA;
        pay_tbl[1] = 16'hBBBB;
        base = flit_cnt;
        flit_cyc.delete();
        send_packet(3, 2, 2, 1'b0);
        wait_flits("t1_flits", base + 3, 20);
        check("t1_flit_cyc_count", flit_cyc.size(), 3);
        if (flit_cyc.size() >= 3) begin
            check("t1_consecutive_a", flit_cyc[1] - flit_cyc[0], 1);
            check("t1_consecutive_b", flit_cyc[2] - flit_cyc[1], 1);
        end

        // Zero-length packet northwards uses the last credit.
        base = flit_cnt;
        send_packet(0, 5, 0, 1'b0);
        wait_flits("t2_flits", base + 1, 20);
        check("t2_busy", busy, 1'b0);
        check("t2_req_ready", bus.req_ready, 1'b1);

        // With no credit the head stalls; a return enables it one cycle later.
        base = flit_cnt;
        send_packet(1, 1, 0, 1'b0);
        repeat (6) tick();
        check("t2b_stalled", flit_cnt, base);
        check("t2b_busy", busy, 1'b1);
        dir_ret = 1'b1;
        tick();
        dir_ret = 1'b0;
        check("t2b_no_early_send", bus.flit_valid, 1'b0);
        tick();
        check("t2b_send", bus.flit_valid, 1'b1);
        tick();

        // Rejected requests: local destination and over-long body.
        do_reset();
        base = flit_cnt;
        n = err_seen;
        send_packet(0, 0, 3, 1'b0);
        send_packet(2, 2, 9, 1'b0);
        repeat (3) tick();
        check("t3_err_pulses", err_seen, n + 2);
        check("t3_no_flits", flit_cnt, base);
        check("t3_busy", busy, 1'b0);

        // Six bodies on four credits: four flits, then one per returned credit.
        for (int i = 0; i < 16; i++) pay_tbl[i] = 16'($urandom);
        base = flit_cnt;
        fork
            send_packet(3, 0, 6, 1'b0);
        join_none
        repeat (15) tick();
        check("t4_credit_limit", flit_cnt, base + 4);
        check("t4_pay_ready_low", bus.pay_ready, 1'b0);
        dir_ret = 1'b1;
        tick();
        dir_ret = 1'b0;
        repeat (4) tick();
        check("t4_one_more", flit_cnt, base + 5);
        repeat (4) begin
            dir_ret = 1'b1;
            tick();
        end
        dir_ret = 1'b0;
        wait_flits("t4_all", base + 7, 20);
        repeat (2) tick();

        // Return coinciding with a body send at credit 2 leaves credit at 2.
        do_reset();
        for (int i = 0; i < 16; i++) pay_tbl[i] = 16'($urandom);
        base = flit_cnt;
        fork
            send_packet(1, 0, 5, 1'b0);
        join_none
        n = 0;
        while (flit_cnt < base + 2 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_two_flits", flit_cnt, base + 2);
        check("t5_send_cycle", bus.pay_ready && bus.pay_valid, 1'b1);
        dir_ret = 1'b1;
        @(posedge clk);
        #1;
        dir_ret = 1'b0;
        repeat (12) tick();
        check("t5_five_flits", flit_cnt, base + 5);
        check("t5_pay_ready_low", bus.pay_ready, 1'b0);
        dir_ret = 1'b1;
        tick();
        dir_ret = 1'b0;
        wait_flits("t5_tail", base + 6, 10);
        repeat (2) tick();

        // Credit overflow while idle is sticky.
        do_reset();
        dir_ret = 1'b1;
        tick();
        dir_ret = 1'b0;
        check("t6_err_credit_set", err_credit, 1'b1);
        repeat (5) tick();
        check("t6_err_credit_sticky", err_credit, 1'b1);

        // Reset in the middle of a packet abandons it and restores credit.
        do_reset();
        router_en = 1'b1;
        for (int i = 0; i < 16; i++) pay_tbl[i] = 16'($urandom);
        base = flit_cnt;
        fork
            send_packet(2, 1, 5, 1'b0);
        join_none
        wait_flits("t7_head_two_bodies", base + 3, 20);
        router_en = 1'b0;
        do_reset();
        base = flit_cnt;
        send_packet(4, 4, 3, 1'b0);
        wait_flits("t7_full_credit", base + 4, 20);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        router_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int rx, ry, rl;
            rx = $urandom_range(0, 7);
            ry = $urandom_range(0, 7);
            rl = $urandom_range(0, 10);
            if ($urandom_range(0, 9) == 0) begin
                rx = LOCAL_X;
                ry = LOCAL_Y;
            end
            for (int i = 0; i < 16; i++) pay_tbl[i] = 16'($urandom);
            send_packet(rx, ry, rl, 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("rand_drain", exp_q.size(), 0);
        check("err_count", err_seen, exp_err);
        router_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xy_flit_injector.md
# xy_flit_injector

Packet transmitter for the XY mesh router's local input port. It takes a packet request (destination coordinates plus a body length) and payload words. It emits a head flit carrying the precomputed first-hop (lookahead) XY port, then the body flits, with the last one marked tail. Flow control toward the router's input buffer is credit-based.

## Interface
Parameters:
- COORD_W, 3, width of each mesh coordinate
- DATA_W, 16, flit payload width; must be ≥ 3 + 2*COORD_W + LEN_W
- MAX_LEN, 8, maximum body flits per packet
- LEN_W, 4, width of length field, equal to clog2(MAX_LEN+1)
- CREDITS, 4, router input buffer depth (initial credit count)
- LOCAL_X, 0, this node's X coordinate
- LOCAL_Y, 0, this node's Y coordinate

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when high together with req_valid
- req_x, req_y  in  COORD_W  destination coordinates
- req_len  in  LEN_W  number of body flits, 0..MAX_LEN
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word consumed when high together with pay_valid
- pay_data  in  DATA_W  payload word
- flit_valid  out  1  registered one-cycle flit strobe; there is no ready signal
- flit_data  out  DATA_W+2  bits [DATA_W+1:DATA_W] carry the type: 01 head, 00 body, 10 tail, 11 head+tail
- credit_ret  in  1  router freed one buffer slot
- err_req  out  1  registered one-cycle pulse when a request is rejected
- err_credit  out  1  sticky flag for credit overflow; cleared only by rst
- busy  out  1  high whenever state is not IDLE

## Operation
States: IDLE, HEAD, BODY.

IDLE:
- req_ready=1.
- On handshake, if (req_x,req_y)==(LOCAL_X,LOCAL_Y) or req_len>MAX_LEN: pulse err_req and stay in IDLE. No flits are sent.
- Otherwise latch x, y and len, compute the port, and go to HEAD.

Port encoding (X dimension first):
- req_x>LOCAL_X → E=1
- req_x<LOCAL_X → W=2
- X equal and req_y>LOCAL_Y → N=3
- X equal and req_y<LOCAL_Y → S=4
- All comparisons are unsigned.

HEAD:
- Waits while credit==0.
- When credit>0, registers the head flit and decrements credit.
- Head payload: low bits {port[2:0], x, y, len}, upper bits zero.
- Head type is 01, or 11 if len==0. If len==0, go to IDLE; otherwise go to BODY with cnt=0.

BODY:
- pay_ready = (state==BODY) && (credit>0). This is combinational from registered state only.
- On each payload handshake: register a flit with pay_data, decrement credit, increment cnt.
- The flit with cnt+1==len is typed tail (10) and returns the FSM to IDLE. All others are typed body (00).

Credit counter:
- Width clog2(CREDITS+1); reset value CREDITS.
- Net update each cycle = +credit_ret − flit_sent. Simultaneous return and send leaves it unchanged.
- A flit may be sent only on the registered count (>0); a same-cycle credit_ret does not enable a send at 0.
- credit_ret while credit==CREDITS with no send that cycle: saturate at CREDITS and set err_credit.

## Timing
- Reset values: req_ready=0 during rst, 1 in IDLE afterwards; pay_ready=0, flit_valid=0, flit_data=0, err_req=0, err_credit=0, busy=0, credit=CREDITS, state=IDLE.
- Request accepted at edge E0. The head flit is registered at E0+1 if credit>0 and flit_valid is high in the cycle after E0+1. Each credit-stall cycle adds one cycle.
- Body latency: a payload handshake at edge Ek gives flit_valid high in the cycle after Ek.
- Throughput is one flit per cycle while credit>0 and pay_valid is held. Back-to-back packets incur one IDLE cycle between a tail flit and the next head acceptance.
- flit_valid is high for exactly one cycle per flit; flit_data holds its value when flit_valid is low.
- rst mid-packet: abandon the packet, go to IDLE, restore credits, and accept no payload. The router side is assumed to be reset concurrently.

## Test plan
- Reset, then request LOCAL=(0,0), dest (3,2), len 2, with payloads 0xAAAA and 0xBBBB → three flits on consecutive cycles: head with port E=1 and x=3 y=2 len=2, body 0xAAAA type 00, tail 0xBBBB type 10; credit ends at 1.
- Request dest (0,5), len 0 → single head+tail flit (type 11, port N=3); FSM back in IDLE and busy=0 the next cycle.
- Request dest (0,0), and separately len 9 → err_req pulses once for each; no flit_valid; credit stays at 4.
- CREDITS=4, len 6, no credit_ret → exactly 4 flits, then pay_ready=0. One credit_ret → exactly one more flit, one cycle after the return is registered.
- credit_ret asserted in the same cycle as a body send at credit=2 → credit stays at 2. credit_ret at credit=4 while idle → err_credit=1 and remains set until rst.
- rst asserted after the 2nd body flit of a len-5 packet → next cycle: flit_valid=0, busy=0, credit=4, req_ready=1.
